// File: rtl/mdu_pkg.sv
// Shared multiply/divide unit definitions: MDUSelect op encoding, FSM states and
// default latencies used by the control unit, Execute and the MDU itself.
package mdu_pkg;

  localparam logic [2:0] MDU_NONE  = 3'd0;
  localparam logic [2:0] MDU_MULT  = 3'd1;
  localparam logic [2:0] MDU_MULTU = 3'd2;
  localparam logic [2:0] MDU_DIV   = 3'd3;
  localparam logic [2:0] MDU_DIVU  = 3'd4;
  localparam logic [2:0] MDU_MTHI  = 3'd5;
  localparam logic [2:0] MDU_MTLO  = 3'd6;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  function automatic logic is_launch_op(input logic [2:0] sel);
    return (sel == MDU_MULT) || (sel == MDU_MULTU) || (sel == MDU_DIV) || (sel == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Combinational 32-bit divider: signed (truncating toward zero, remainder takes the
// dividend's sign) or unsigned quotient/remainder, with a divide-by-zero flag.
module mdu_div_core
  import mdu_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        signed_i,
  output logic [31:0] quot_o,
  output logic [31:0] rem_o,
  output logic        div_zero_o
);

  logic        neg_a;
  logic        neg_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] safe_b;
  logic [31:0] uq;
  logic [31:0] ur;

  // Divide magnitudes and re-apply signs; 0x80000000 / -1 wraps back to 0x80000000.
  always_comb begin
    neg_a      = signed_i & a_i[31];
    neg_b      = signed_i & b_i[31];
    mag_a      = neg_a ? (32'd0 - a_i) : a_i;
    mag_b      = neg_b ? (32'd0 - b_i) : b_i;
    div_zero_o = (b_i == 32'd0);
    safe_b     = div_zero_o ? 32'd1 : mag_b;
    uq         = mag_a / safe_b;
    ur         = mag_a % safe_b;
    quot_o     = (neg_a ^ neg_b) ? (32'd0 - uq) : uq;
    rem_o      = neg_a ? (32'd0 - ur) : ur;
  end

endmodule

// File: rtl/mdu_iterative.sv
// Multi-cycle multiply/divide unit answering Execute's Start/Busy handshake. The result
// is computed at launch and held in pending registers until the last busy cycle.
module mdu_iterative
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  MDUSelect,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  mdu_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             busy_q;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;
  logic [31:0]      p_hi_q;
  logic [31:0]      p_lo_q;
  logic [63:0]      res_d;
  logic             launch;

  logic signed [31:0] a_s;
  logic signed [31:0] b_s;
  logic signed [63:0] mul_s;
  logic [63:0]        mul_u;
  logic [31:0]        quot;
  logic [31:0]        rem;
  logic               div_zero;

  mdu_div_core u_div (
    .a_i        (A),
    .b_i        (B),
    .signed_i   (MDUSelect == MDU_DIV),
    .quot_o     (quot),
    .rem_o      (rem),
    .div_zero_o (div_zero)
  );

  assign a_s   = A;
  assign b_s   = B;
  assign mul_s = a_s * b_s;
  assign mul_u = {32'd0, A} * {32'd0, B};

  assign launch = (state_q == ST_IDLE) & Start & is_launch_op(MDUSelect);

  // A divide by zero re-commits the current HI/LO, which cannot change while busy.
  always_comb begin
    res_d = {hi_q, lo_q};
    cnt_d = CNT_W'(DIV_CYCLES);
    case (MDUSelect)
      MDU_MULT: begin
        res_d = mul_s;
        cnt_d = CNT_W'(MULT_CYCLES);
      end
      MDU_MULTU: begin
        res_d = mul_u;
        cnt_d = CNT_W'(MULT_CYCLES);
      end
      MDU_DIV, MDU_DIVU: begin
        if (!div_zero) res_d = {rem, quot};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      p_hi_q  <= '0;
      p_lo_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (launch) begin
            p_hi_q  <= res_d[63:32];
            p_lo_q  <= res_d[31:0];
            cnt_q   <= cnt_d;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end else if (!Start && MDUSelect == MDU_MTHI) begin
            hi_q <= A;
          end else if (!Start && MDUSelect == MDU_MTLO) begin
            lo_q <= A;
          end
        end
        ST_RUN: begin
          if (cnt_q == CNT_W'(1)) begin
            hi_q    <= p_hi_q;
            lo_q    <= p_lo_q;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign Busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

  // Decode's hazard logic should never let these through; they are dropped if it does.
  a_no_start_busy: assert property (@(posedge clk) disable iff (!reset)
    !(busy_q && Start))
    else $warning("mdu_iterative: Start while Busy dropped");

  a_no_mt_busy: assert property (@(posedge clk) disable iff (!reset)
    !(busy_q && !Start && (MDUSelect == MDU_MTHI || MDUSelect == MDU_MTLO)))
    else $warning("mdu_iterative: MTHI/MTLO while Busy dropped");

endmodule

// File: tb/tb_mdu_iterative.sv
// Bench for mdu_iterative: directed scenarios with literal expectations plus randomized
// traffic, all compared every cycle against a cycles-remaining behavioural model.
module tb_mdu_iterative;

  localparam int NMUL = 5;
  localparam int NDIV = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [2:0]  MDUSelect;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_assert = 0;
  int n_fail   = 0;

  mdu_iterative #(.MULT_CYCLES(NMUL), .DIV_CYCLES(NDIV)) dut (
    .clk       (clk),
    .reset     (reset),
    .Start     (Start),
    .MDUSelect (MDUSelect),
    .A         (A),
    .B         (B),
    .Busy      (Busy),
    .HI        (HI),
    .LO        (LO)
  );

  always #5 clk = ~clk;

  // Architectural result of an op, as {HI, LO}.
  function automatic logic [63:0] ref_result(input logic [2:0] sel, input logic [31:0] a,
                                             input logic [31:0] b);
    longint          sa, sb, sp, sq, sr;
    longint unsigned ua, ub, up;
    logic [63:0]     r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    r  = '0;
    case (sel)
      3'd1: begin sp = sa * sb; r = sp; end
      3'd2: begin up = ua * ub; r = up; end
      3'd3: begin sq = sa / sb; sr = sa % sb; r = {sr[31:0], sq[31:0]}; end
      3'd4: begin r = {32'(ua % ub), 32'(ua / ub)}; end
      default: r = '0;
    endcase
    return r;
  endfunction

  // Model: HI/LO, cycles left of Busy, and the value to commit when they run out.
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  int          m_left;
  logic        m_wr;
  logic [63:0] m_res;

  assign m_res = ref_result(MDUSelect, A, B);

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_hi   <= '0;
      m_lo   <= '0;
      m_left <= 0;
      m_wr   <= 1'b0;
      m_phi  <= '0;
      m_plo  <= '0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1 && m_wr) begin
        m_hi <= m_phi;
        m_lo <= m_plo;
      end
    end else if (Start && MDUSelect >= 3'd1 && MDUSelect <= 3'd4) begin
      m_left <= (MDUSelect <= 3'd2) ? NMUL : NDIV;
      m_wr   <= !(MDUSelect >= 3'd3 && B == 32'd0);
      m_phi  <= m_res[63:32];
      m_plo  <= m_res[31:0];
    end else if (!Start && MDUSelect == 3'd5) begin
      m_hi <= A;
    end else if (!Start && MDUSelect == 3'd6) begin
      m_lo <= A;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    chk("busy", {31'd0, Busy}, {31'd0, (m_left != 0)});
    chk("hi", HI, m_hi);
    chk("lo", LO, m_lo);
  endtask

  // Apply inputs for the next rising edge, then compare at the following falling edge.
  task automatic drive(input logic st, input logic [2:0] sel, input logic [31:0] a,
                       input logic [31:0] b);
    Start = st; MDUSelect = sel; A = a; B = b;
    @(negedge clk);
    cmp_model();
  endtask

  task automatic op(input string nm, input logic [2:0] sel, input logic [31:0] a,
                    input logic [31:0] b, input int ncyc, input logic [31:0] ehi,
                    input logic [31:0] elo);
    int n;
    n = 0;
    drive(1'b1, sel, a, b);
    while (Busy && n < 100) begin
      n++;
      drive(1'b0, 3'd0, 32'd0, 32'd0);
    end
    chk({nm, "_cycles"}, 32'(n), 32'(ncyc));
    chk({nm, "_hi"}, HI, ehi);
    chk({nm, "_lo"}, LO, elo);
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    logic [2:0] s;
    reset = 1'b0; Start = 1'b0; MDUSelect = 3'd0; A = '0; B = '0;
    #3;
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    op("mult_neg", 3'd1, 32'hFFFF_FFFE, 32'd3, NMUL, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    op("multu", 3'd2, 32'hFFFF_FFFF, 32'd2, NMUL, 32'h0000_0001, 32'hFFFF_FFFE);
    op("div_neg", 3'd3, 32'hFFFF_FFF9, 32'd2, NDIV, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    op("div_negb", 3'd3, 32'd7, 32'hFFFF_FFFE, NDIV, 32'h0000_0001, 32'hFFFF_FFFD);
    op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, NDIV, 32'h0, 32'h8000_0000);

    drive(1'b0, 3'd5, 32'h11, 32'd0);
    drive(1'b0, 3'd6, 32'h22, 32'd0);
    op("divu_zero", 3'd4, 32'd7, 32'd0, NDIV, 32'h11, 32'h22);
    op("div_zero", 3'd3, 32'hFFFF_FFF0, 32'd0, NDIV, 32'h11, 32'h22);

    drive(1'b0, 3'd5, 32'h1234, 32'd0);
    chk("mthi_busy", {31'd0, Busy}, 32'd0);
    drive(1'b0, 3'd6, 32'h5678, 32'd0);
    chk("mtlo_busy", {31'd0, Busy}, 32'd0);
    chk("mthi_hi", HI, 32'h1234);
    chk("mtlo_lo", LO, 32'h5678);
    drive(1'b1, 3'd5, 32'hDEAD, 32'd0);
    drive(1'b0, 3'd7, 32'hBEEF, 32'd0);
    chk("ignored_hi", HI, 32'h1234);

    // Relaunch attempt in busy cycle 2 must neither restart nor retime the MULT.
    drive(1'b1, 3'd1, 32'd3, 32'd5);
    n = 0;
    while (Busy && n < 100) begin
      n++;
      if (n == 2) drive(1'b1, 3'd1, 32'd7, 32'd7);
      else drive(1'b0, 3'd0, 32'd0, 32'd0);
    end
    chk("relaunch_cycles", 32'(n), 32'(NMUL));
    chk("relaunch_lo", LO, 32'd15);

    // Asynchronous abort in busy cycle 4.
    drive(1'b1, 3'd3, 32'd100, 32'd3);
    for (int i = 0; i < 3; i++) drive(1'b0, 3'd0, 32'd0, 32'd0);
    chk("abort_pre_busy", {31'd0, Busy}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("abort_busy", {31'd0, Busy}, 32'd0);
    chk("abort_hi", HI, 32'd0);
    chk("abort_lo", LO, 32'd0);
    for (int i = 0; i < 3; i++) drive(1'b0, 3'd0, 32'd0, 32'd0);
    reset = 1'b1;
    for (int i = 0; i < NDIV; i++) drive(1'b0, 3'd0, 32'd0, 32'd0);
    chk("abort_nowrite_lo", LO, 32'd0);
    op("post_reset", 3'd1, 32'd3, 32'd4, NMUL, 32'd0, 32'd12);

    op("b2b_mult", 3'd1, 32'd2, 32'd3, NMUL, 32'd0, 32'd6);
    op("b2b_divu", 3'd4, 32'd100, 32'd7, NDIV, 32'd2, 32'd14);

    for (int i = 0; i < 600; i++) begin
      if (Busy) begin
        s = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'd7;
        drive(1'b0, s, rnd_operand(), rnd_operand());
      end else begin
        case ($urandom_range(0, 5))
          0, 1: drive(1'b1, 3'($urandom_range(1, 4)), rnd_operand(), rnd_operand());
          2: drive(1'b0, 3'($urandom_range(5, 6)), $urandom, rnd_operand());
          3: drive(1'b1, ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(5, 7)),
                   $urandom, $urandom);
          default: drive(1'b0, 3'($urandom_range(0, 4)), $urandom, $urandom);
        endcase
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
